// File: rtl/board_dump_uart_tx_pkg.sv
// Shared Game of Life board definitions used by the board dump path:
// board geometry, the ASCII characters emitted per cell / line end, and the
// dump FSM state encoding.
package board_dump_uart_tx_pkg;

  localparam int GOL_ROWS   = 16;
  localparam int GOL_COLS   = 20;
  localparam int GOL_ADDR_W = 4;

  localparam logic [7:0] CH_ALIVE = 8'h23;  // '#'
  localparam logic [7:0] CH_DEAD  = 8'h2E;  // '.'
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_CR,
    ST_LF,
    ST_WAIT_LAST
  } dump_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter, LSB first, one bit every DIV = CLK_HZ/BAUD clocks.
// Ports:
//   clk_50MHz_i     system clock
//   rst_async_la_i  async active-low reset (line returns high immediately)
//   data_i/valid_i  byte offered; transfers on a cycle with valid_i && ready_o
//   ready_o         transmitter free (idle, or in the last cycle of a stop bit)
//   tx_o            serial line, idles high
module uart_tx_byte #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_50MHz_i,
  input  logic       rst_async_la_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  logic          busy;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;   // 0 start, 1..8 data, 9 stop
  logic [8:0]    shreg;     // remaining data bits plus stop bit
  logic          bit_end;
  logic          last_cyc;

  assign bit_end  = (baud_cnt == DIV_M1);
  assign last_cyc = busy && bit_end && (bit_cnt == 4'd9);
  // Accepting in the final stop-bit cycle lets the next start bit begin
  // right after the stop bit, keeping every bit exactly DIV clocks.
  assign ready_o  = !busy || last_cyc;

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx_o     <= 1'b1;
    end else if (valid_i && ready_o) begin
      busy     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= {1'b1, data_i};
      tx_o     <= 1'b0;
    end else if (busy) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          busy    <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx_o    <= shreg[0];
          shreg   <= {1'b0, shreg[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_dump_uart_tx.sv
// Dumps the Game of Life board as ASCII over UART: per row, COLS chars
// ('#' set / '.' clear, leftmost = MSB) then CR LF.
// Ports:
//   clk_50MHz_i     system clock
//   rst_async_la_i  async active-low reset
//   start_i         one-shot start pulse (ignored while busy or during done_o)
//   ram_addr_o      row address to the synchronous RAM read port
//   ram_data_i      row data, valid one cycle after ram_addr_o
//   tx_o            UART line
//   busy_o          dump in progress (top level muxes the RAM port on this)
//   done_o          one-cycle pulse once the last stop bit has finished
module board_dump_uart_tx
  import board_dump_uart_tx_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int ROWS   = GOL_ROWS,
  parameter int COLS   = GOL_COLS,
  parameter int ADDR_W = GOL_ADDR_W
) (
  input  logic              clk_50MHz_i,
  input  logic              rst_async_la_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [COLS-1:0]   ram_data_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);

  dump_state_t       state;
  logic [ADDR_W-1:0] row;
  logic [COL_W-1:0]  col;
  logic [COLS-1:0]   shreg;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              accept;

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = CH_LF;
    case (state)
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shreg[COLS-1] ? CH_ALIVE : CH_DEAD;
      end
      ST_CR: begin
        tx_valid = 1'b1;
        tx_data  = CH_CR;
      end
      ST_LF: begin
        tx_valid = 1'b1;
        tx_data  = CH_LF;
      end
      default: ;
    endcase
  end

  assign accept = tx_valid && tx_ready;

  always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
    if (!rst_async_la_i) begin
      state      <= ST_IDLE;
      row        <= '0;
      col        <= '0;
      shreg      <= '0;
      ram_addr_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          // done_o high means we are in the cycle right after a dump ended;
          // a start there is dropped rather than chaining a second dump.
          if (start_i && !done_o) begin
            state      <= ST_FETCH;
            busy_o     <= 1'b1;
            row        <= '0;
            ram_addr_o <= '0;
          end
        end
        ST_FETCH: state <= ST_LATCH;
        ST_LATCH: begin
          shreg <= ram_data_i;
          col   <= '0;
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (accept) begin
            shreg <= {shreg[COLS-2:0], 1'b0};
            if (col == COL_LAST) state <= ST_CR;
            else                 col   <= col + 1'b1;
          end
        end
        ST_CR: if (accept) state <= ST_LF;
        ST_LF: begin
          // The next row is fetched while LF is still on the wire, so rows
          // stream with no gap between frames.
          if (accept) begin
            if (row == ROW_LAST) begin
              state <= ST_WAIT_LAST;
            end else begin
              row        <= row + 1'b1;
              ram_addr_o <= row + 1'b1;
              state      <= ST_FETCH;
            end
          end
        end
        ST_WAIT_LAST: begin
          // ready rises in the final stop-bit cycle: the line is done at
          // this edge.
          if (tx_ready) begin
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            row        <= '0;
            col        <= '0;
            ram_addr_o <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_tx (
    .clk_50MHz_i    (clk_50MHz_i),
    .rst_async_la_i (rst_async_la_i),
    .data_i         (tx_data),
    .valid_i        (tx_valid),
    .ready_o        (tx_ready),
    .tx_o           (tx_o)
  );

endmodule
